// File: rtl/piezo_rx_if.sv
// Piezo receive conditioner bundle: control/config in,
// detect pulse, status and counters out.
interface piezo_rx_if #(
  parameter int CNT_W  = 16,
  parameter int FLT_W  = 8,
  parameter int STAT_W = 16
);
  logic              enable;
  logic              piezo_raw_in;
  logic              tx_active;
  logic [FLT_W-1:0]  filter_len;
  logic [CNT_W-1:0]  blank_cycles;
  logic [CNT_W-1:0]  rearm_low;
  logic              clear_counts;
  logic              piezo_detect;
  logic              piezo_detect_level;
  logic              armed;
  logic [STAT_W-1:0] event_count;
  logic [STAT_W-1:0] glitch_count;

  modport master (
    output enable, piezo_raw_in, tx_active,
    output filter_len, blank_cycles, rearm_low,
    output clear_counts,
    input  piezo_detect, piezo_detect_level, armed,
    input  event_count, glitch_count
  );

  modport slave (
    input  enable, piezo_raw_in, tx_active,
    input  filter_len, blank_cycles, rearm_low,
    input  clear_counts,
    output piezo_detect, piezo_detect_level, armed,
    output event_count, glitch_count
  );
endinterface

// File: rtl/piezo_rx_conditioner.sv
// Piezo receive front end: sync, self-blanking, glitch filter,
// one detect pulse per acoustic arrival, saturating counters.
module piezo_rx_conditioner #(
  parameter int CNT_W  = 16,
  parameter int FLT_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic     clock,
  input  logic     reset,
  piezo_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, BLANK, ARMED, QUALIFY, HOLD
  } state_t;

  state_t state, state_n;

  logic             s1, sync_in;
  logic [FLT_W-1:0] flt_q, qual_cnt, qual_n, qual_inc;
  logic [CNT_W-1:0] blank_q, rearm_q;
  logic [CNT_W-1:0] blank_cnt, blank_n;
  logic [CNT_W-1:0] low_cnt, low_n, low_inc;
  logic             det, ev_inc, gl_inc, latch;

  always_comb begin
    state_n  = state;
    blank_n  = blank_cnt;
    qual_n   = qual_cnt;
    low_n    = low_cnt;
    det      = 1'b0;
    ev_inc   = 1'b0;
    gl_inc   = 1'b0;
    latch    = 1'b0;
    qual_inc = qual_cnt + FLT_W'(1);
    low_inc  = low_cnt + CNT_W'(1);
    if (!bus.enable) begin
      state_n = IDLE;
    end else if (bus.tx_active && state != IDLE) begin
      // own burst: drop everything and restart blanking
      state_n = BLANK;
      blank_n = blank_q;
    end else begin
      unique case (state)
        IDLE: begin
          latch   = 1'b1;
          blank_n = bus.blank_cycles;
          state_n = BLANK;
        end
        BLANK: begin
          if (blank_cnt == '0) state_n = ARMED;
          else blank_n = blank_cnt - CNT_W'(1);
        end
        ARMED: begin
          if (sync_in) begin
            if (flt_q <= FLT_W'(1)) begin
              state_n = HOLD;
              det     = 1'b1;
              ev_inc  = 1'b1;
              low_n   = '0;
            end else begin
              state_n = QUALIFY;
              qual_n  = FLT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (sync_in) begin
            qual_n = qual_inc;
            if (qual_inc >= flt_q) begin
              state_n = HOLD;
              det     = 1'b1;
              ev_inc  = 1'b1;
              low_n   = '0;
            end
          end else begin
            state_n = ARMED;
            gl_inc  = 1'b1;
          end
        end
        HOLD: begin
          if (sync_in) begin
            low_n = '0;
          end else begin
            low_n = low_inc;
            // rearm_low of 0 behaves as 1
            if (low_inc >= rearm_q) state_n = ARMED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      s1        <= 1'b0;
      sync_in   <= 1'b0;
      flt_q     <= '0;
      blank_q   <= '0;
      rearm_q   <= '0;
      blank_cnt <= '0;
      qual_cnt  <= '0;
      low_cnt   <= '0;
    end else begin
      state     <= state_n;
      s1        <= bus.piezo_raw_in;
      sync_in   <= s1;
      blank_cnt <= blank_n;
      qual_cnt  <= qual_n;
      low_cnt   <= low_n;
      if (latch) begin
        flt_q   <= bus.filter_len;
        blank_q <= bus.blank_cycles;
        rearm_q <= bus.rearm_low;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.clear_counts) begin
      bus.event_count  <= '0;
      bus.glitch_count <= '0;
    end else begin
      if (ev_inc && !(&bus.event_count))
        bus.event_count <= bus.event_count + STAT_W'(1);
      if (gl_inc && !(&bus.glitch_count))
        bus.glitch_count <= bus.glitch_count + STAT_W'(1);
    end
  end

  assign bus.piezo_detect       = det;
  assign bus.piezo_detect_level = (state == HOLD);
  assign bus.armed = (state == ARMED) || (state == QUALIFY);

endmodule

// File: tb/tb_piezo_rx_conditioner.sv
// Bench for piezo_rx_conditioner: vector table plus corner
// sequences, detect pulses checked against a cycle scoreboard.
`timescale 1ns/1ps
module tb_piezo_rx_conditioner;

  localparam int SW = 10;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct {
    int flt;
    int len;
    bit det;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   sb[$];
  int   exp_c;
  bit   prev_det = 1'b0;
  int   exp_ev = 0;
  int   exp_gl = 0;
  vec_t vt[10];

  piezo_rx_if #(.CNT_W(16), .FLT_W(8), .STAT_W(SW)) bus ();

  piezo_rx_conditioner #(.CNT_W(16), .FLT_W(8), .STAT_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset === 1'b0 && bus.piezo_detect === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL det_unexp: pulse at cycle %0d, none due", cyc);
      end else begin
        exp_c = sb.pop_front();
        if (exp_c != cyc || prev_det) begin
          bad++;
          $display("FAIL det_cycle: got cycle %0d want %0d (prev=%0b)",
                   cyc, exp_c, prev_det);
        end
      end
    end
    prev_det = (bus.piezo_detect === 1'b1);
  end

  initial begin
    #(20 * 60000);
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic look();
    #5;
  endtask

  task automatic wait_armed(input int lim);
    int n;
    n = 0;
    look();
    while (bus.armed !== 1'b1 && n < lim) begin
      tick();
      look();
      n++;
    end
    chk("armed_wait", 32'(bus.armed), 1);
  endtask

  task automatic cfg(input int flt, input int blk, input int rl);
    tick();
    bus.enable = 1'b0;
    bus.piezo_raw_in = 1'b0;
    bus.tx_active = 1'b0;
    bus.filter_len = 8'(flt);
    bus.blank_cycles = 16'(blk);
    bus.rearm_low = 16'(rl);
    tick();
    bus.enable = 1'b1;
    wait_armed(blk + 20);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_ev"}, 32'(bus.event_count), exp_ev);
    chk({nm, "_gl"}, 32'(bus.glitch_count), exp_gl);
  endtask

  initial begin
    int c, t1;
    vt[0] = '{8, 3, 1'b0};
    vt[1] = '{8, 7, 1'b0};
    vt[2] = '{8, 8, 1'b1};
    vt[3] = '{8, 40, 1'b1};
    vt[4] = '{1, 1, 1'b1};
    vt[5] = '{0, 1, 1'b1};
    vt[6] = '{2, 1, 1'b0};
    vt[7] = '{2, 2, 1'b1};
    vt[8] = '{5, 4, 1'b0};
    vt[9] = '{20, 20, 1'b1};

    bus.enable = 1'b1;
    bus.piezo_raw_in = 1'b0;
    bus.tx_active = 1'b0;
    bus.filter_len = 8'd8;
    bus.blank_cycles = 16'd4;
    bus.rearm_low = 16'd3;
    bus.clear_counts = 1'b0;

    // reset held 3 cycles with enable already high
    repeat (3) begin
      tick();
      look();
      chk("rst_det", 32'(bus.piezo_detect), 0);
      chk("rst_lvl", 32'(bus.piezo_detect_level), 0);
      chk("rst_armed", 32'(bus.armed), 0);
      chk("rst_ev", 32'(bus.event_count), 0);
      chk("rst_gl", 32'(bus.glitch_count), 0);
    end
    tick();
    reset = 1'b0;
    repeat (5) tick();
    look();
    chk("armed_c5", 32'(bus.armed), 0);
    tick();
    look();
    chk("armed_c6", 32'(bus.armed), 1);

    // clean arrival, filter 8, rearm 3
    tick();
    bus.piezo_raw_in = 1'b1;
    c = cyc;
    sb.push_back(c + 9);
    exp_ev++;
    repeat (40) tick();
    bus.piezo_raw_in = 1'b0;
    repeat (4) tick();
    look();
    chk("lvl_f4", 32'(bus.piezo_detect_level), 1);
    tick();
    look();
    chk("lvl_f5", 32'(bus.piezo_detect_level), 0);
    chk("armed_f5", 32'(bus.armed), 1);
    chk_counts("clean");

    // glitches of 3 and 7 cycles
    tick();
    bus.piezo_raw_in = 1'b1;
    repeat (3) tick();
    bus.piezo_raw_in = 1'b0;
    repeat (8) tick();
    bus.piezo_raw_in = 1'b1;
    repeat (7) tick();
    bus.piezo_raw_in = 1'b0;
    look();
    chk("armed_qual", 32'(bus.armed), 1);
    repeat (8) tick();
    look();
    exp_gl += 2;
    chk_counts("glitch");
    chk("armed_glitch", 32'(bus.armed), 1);

    foreach (vt[i]) begin
      cfg(vt[i].flt, 2, 3);
      tick();
      bus.piezo_raw_in = 1'b1;
      c = cyc;
      if (vt[i].det) begin
        sb.push_back(c + ((vt[i].flt == 0) ? 1 : vt[i].flt) + 1);
        exp_ev++;
      end else begin
        exp_gl++;
      end
      repeat (vt[i].len) tick();
      bus.piezo_raw_in = 1'b0;
      repeat (12) tick();
      look();
      chk_counts($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_armed", i), 32'(bus.armed), 1);
    end

    // self blanking across own burst
    cfg(8, 50, 3);
    tick();
    bus.tx_active = 1'b1;
    bus.piezo_raw_in = 1'b1;
    repeat (100) tick();
    bus.tx_active = 1'b0;
    t1 = cyc;
    repeat (30) tick();
    bus.piezo_raw_in = 1'b0;
    look();
    chk("blank_armed", 32'(bus.armed), 0);
    repeat (30) tick();
    bus.piezo_raw_in = 1'b1;
    c = cyc;
    chk("blank_gap", c - t1, 60);
    sb.push_back(c + 9);
    exp_ev++;
    repeat (20) tick();
    bus.piezo_raw_in = 1'b0;
    repeat (10) tick();
    look();
    chk_counts("blank");

    // tx_active on the qualifying cycle
    cfg(8, 2, 3);
    tick();
    bus.piezo_raw_in = 1'b1;
    repeat (9) tick();
    bus.tx_active = 1'b1;
    look();
    chk("prio_det", 32'(bus.piezo_detect), 0);
    tick();
    bus.tx_active = 1'b0;
    bus.piezo_raw_in = 1'b0;
    look();
    chk("prio_armed", 32'(bus.armed), 0);
    chk("prio_lvl", 32'(bus.piezo_detect_level), 0);
    wait_armed(20);
    chk_counts("prio");

    // enable dropped mid-QUALIFY
    cfg(8, 2, 3);
    tick();
    bus.piezo_raw_in = 1'b1;
    repeat (5) tick();
    bus.enable = 1'b0;
    look();
    chk("dq_armed0", 32'(bus.armed), 1);
    tick();
    look();
    chk("dq_armed1", 32'(bus.armed), 0);
    repeat (10) tick();
    look();
    chk_counts("dis_qual");

    // enable dropped mid-HOLD
    cfg(1, 2, 3);
    tick();
    bus.piezo_raw_in = 1'b1;
    sb.push_back(cyc + 2);
    exp_ev++;
    repeat (4) tick();
    bus.enable = 1'b0;
    look();
    chk("dh_lvl0", 32'(bus.piezo_detect_level), 1);
    tick();
    look();
    chk("dh_lvl1", 32'(bus.piezo_detect_level), 0);
    chk("dh_armed", 32'(bus.armed), 0);
    chk_counts("dis_hold");

    // event counter saturation
    cfg(1, 2, 1);
    repeat (SMAX + 4) begin
      tick();
      bus.piezo_raw_in = 1'b1;
      sb.push_back(cyc + 2);
      tick();
      bus.piezo_raw_in = 1'b0;
    end
    repeat (6) tick();
    look();
    chk("ev_sat", 32'(bus.event_count), SMAX);

    // glitch counter saturation
    cfg(2, 2, 1);
    repeat (SMAX + 4) begin
      tick();
      bus.piezo_raw_in = 1'b1;
      tick();
      bus.piezo_raw_in = 1'b0;
    end
    repeat (6) tick();
    look();
    chk("gl_sat", 32'(bus.glitch_count), SMAX);
    chk("ev_hold", 32'(bus.event_count), SMAX);

    // clear coinciding with a detect
    cfg(1, 2, 1);
    tick();
    bus.piezo_raw_in = 1'b1;
    sb.push_back(cyc + 2);
    tick();
    bus.piezo_raw_in = 1'b0;
    tick();
    bus.clear_counts = 1'b1;
    look();
    chk("clr_det", 32'(bus.piezo_detect), 1);
    tick();
    bus.clear_counts = 1'b0;
    look();
    chk("clr_ev", 32'(bus.event_count), 0);
    chk("clr_gl", 32'(bus.glitch_count), 0);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piezo_rx_conditioner.md
Name: piezo_rx_conditioner

Overview:
Receive-side front end for the ultrasonic PTP link, directly upstream of the PTP controller's piezo input. Synchronises the raw comparator output of the piezo receiver and blanks it during and after the node's own transmit burst. Glitch-filters what remains and emits one single-cycle detect pulse per genuine acoustic arrival, so the PTP counters see exactly one event per burst. Also keeps saturating event and glitch counters for HPS readout.

Parameters:
CNT_W, 16, width of the blank/re-arm timers and config inputs
FLT_W, 8, width of the filter-length config input
STAT_W, 16, width of the saturating status counters

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  block enable; low forces IDLE
piezo_raw_in  in  1  asynchronous comparator output from the piezo receiver
tx_active  in  1  high while this node drives its own piezo burst
filter_len  in  FLT_W  consecutive high samples needed to accept an arrival; 0 is treated as 1
blank_cycles  in  CNT_W  blanking cycles after tx_active falls
rearm_low  in  CNT_W  consecutive low samples needed after a detect before re-arming; 0 is treated as 1
clear_counts  in  1  single-cycle clear of the status counters
piezo_detect  out  1  single-cycle arrival pulse, feeds the PTP piezo input
piezo_detect_level  out  1  high from detect until re-arm (debug/LED)
armed  out  1  high in ARMED and QUALIFY
event_count  out  STAT_W  accepted arrivals, saturating
glitch_count  out  STAT_W  rejected high runs shorter than filter_len, saturating

Behaviour:
- Reset (synchronous): state=IDLE.
  - All outputs 0.
  - Synchroniser flops 0.
  - Counters 0.
  - Latched config 0.
- Synchroniser: piezo_raw_in passes through two flops to give sync_in. All decisions use sync_in only.
- Config latch: filter_len, blank_cycles and rearm_low are latched on the IDLE exit cycle. Changes while enabled are ignored until the next IDLE exit.
- States and transitions:
  - IDLE: enable=0 is forced here from any state in the next cycle. enable=1 latches config and goes to BLANK with blank_cnt=blank_cycles.
  - BLANK: while tx_active=1, blank_cnt reloads to blank_cycles. When tx_active=0, blank_cnt decrements; at 0, go to ARMED. blank_cycles=0 with tx_active=0 gives exactly one cycle in BLANK.
  - ARMED: sync_in=1 goes to QUALIFY with qual_cnt=1.
  - QUALIFY:
    - sync_in=1 increments qual_cnt.
    - When qual_cnt reaches the latched filter_len, go to HOLD; piezo_detect=1 for that transition cycle only, and event_count increments.
    - sync_in=0 before that returns to ARMED and increments glitch_count.
    - With filter_len<=1, the ARMED sample itself qualifies: ARMED goes directly to HOLD with the pulse.
  - HOLD: piezo_detect_level=1.
    - sync_in=0 increments low_cnt; sync_in=1 resets low_cnt to 0.
    - low_cnt reaching rearm_low goes to ARMED and drops piezo_detect_level.
- tx_active priority: tx_active=1 in ARMED, QUALIFY or HOLD goes to BLANK (reload) in the next cycle. It suppresses any piezo_detect due that cycle, drops piezo_detect_level, and increments neither counter.
- Latency: if sync_in first goes high in cycle k and stays high, piezo_detect is high in cycle k+filter_len-1 when filter_len>=1. End-to-end from piezo_raw_in is 2 cycles more.
- piezo_detect is never high in two consecutive cycles. Exactly one pulse occurs per accepted high run.
- Counters saturate at all-ones. When clear_counts coincides with an increment, clear wins and the counter reads 0.
- enable falling mid-QUALIFY or mid-HOLD: next cycle is IDLE, no pulse, and counters are held.

Test Plan:
- Reset/enable: reset 3 cycles, enable=1, blank_cycles=4, tx_active=0 -> armed rises 5 cycles after enable. All outputs stay 0 during reset.
- Clean arrival: filter_len=8, raw high for 40 cycles -> one piezo_detect exactly 9 cycles after raw rises. event_count=1, level stays high until 3 low cycles after raw falls (rearm_low=3).
- Glitch reject: filter_len=8, raw pulses of 3 and 7 cycles -> no piezo_detect, glitch_count=2, armed stays high.
- Self-blanking: tx_active high 100 cycles with raw high throughout, blank_cycles=50, raw falling 30 cycles after tx -> no detect, event_count=0. A raw pulse of 20 cycles starting 60 cycles after tx falls gives one detect.
- Priority and clear: tx_active asserted on the qualifying cycle -> no pulse and state=BLANK. clear_counts with event_count=0xFFFF plus a simultaneous detect -> event_count=0.
- Saturation/disable: 65536 accepted arrivals -> event_count=0xFFFF. enable dropped mid-HOLD -> IDLE next cycle with level=0.
